game_sequencer: RTL and testbench
=================================

GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 The block SHALL have the parameter WIN_SCORE, default 9, meaning the points needed to win a match (legal range 1..15).
REQ-002 The block SHALL have the parameter SERVE_DELAY, default 50000000, meaning the cycles the ball is held before each serve (legal range 1..2^26-1).
REQ-003 The block SHALL have the port clk, input, 1 bit: the system clock; all logic is on its rising edge.
REQ-004 The block SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have the port start, input, 1 bit: a level from a debounced pushbutton, synchronous to clk.
REQ-006 The block SHALL have the port p1_point, input, 1 bit: a single-cycle pulse meaning player 1 won the rally.
REQ-007 The block SHALL have the port p2_point, input, 1 bit: a single-cycle pulse meaning player 2 won the rally.
REQ-008 The block SHALL have the port p1_score, output, 4 bits: player 1's registered score.
REQ-009 The block SHALL have the port p2_score, output, 4 bits: player 2's registered score.
REQ-010 The block SHALL have the port ball_reset, output, 1 bit: holds the ball at centre while high.
REQ-011 The block SHALL have the port play_en, output, 1 bit: enables ball and paddle motion.
REQ-012 The block SHALL have the port serve_dir, output, 1 bit: the initial ball direction (0 = toward player 1, 1 = toward player 2).
REQ-013 The block SHALL have the port game_over, output, 1 bit: high while the match is finished.
REQ-014 The block SHALL have the port winner, output, 2 bits: 00 = none, 01 = player 1, 10 = player 2.
REQ-015 The block SHALL have the port state, output, 3 bits: the current FSM state, for debug.

Function
REQ-016 The FSM SHALL have exactly these states and encodings: IDLE=0, SERVE_WAIT=1, PLAY=2, POINT=3, GAME_OVER=4.
REQ-017 start SHALL be edge-detected internally; a "start event" means start is 1 this cycle and was 0 last cycle.
REQ-018 IDLE SHALL drive ball_reset=1, play_en=0 and winner=00, and on a start event SHALL go to SERVE_WAIT with the serve counter loaded.
REQ-019 SERVE_WAIT SHALL drive ball_reset=1 and play_en=0, and SHALL last exactly SERVE_DELAY cycles before entering PLAY.
REQ-020 PLAY SHALL drive ball_reset=0 and play_en=1.
REQ-021 In PLAY, a p1_point pulse with no p2_point pulse SHALL increment p1_score, set serve_dir=1 (serve toward the player who conceded) and go to POINT; all three updates are visible on the next cycle.
REQ-022 In PLAY, a p2_point pulse with no p1_point pulse SHALL increment p2_score, set serve_dir=0 and go to POINT.
REQ-023 In PLAY, simultaneous p1_point and p2_point SHALL leave both scores and serve_dir unchanged, and SHALL go to SERVE_WAIT (replay).
REQ-024 POINT SHALL last one cycle with ball_reset=1 and play_en=0.
REQ-025 On leaving POINT, if either score equals WIN_SCORE the FSM SHALL go to GAME_OVER, otherwise to SERVE_WAIT with the counter loaded.
REQ-026 Point pulses in any state other than PLAY SHALL be ignored.
REQ-027 A score SHALL never exceed WIN_SCORE; there SHALL be no 4-bit wrap-around.
REQ-028 GAME_OVER SHALL drive game_over=1, ball_reset=1 and play_en=0, hold winner and both scores, and on a start event SHALL clear both scores, clear winner, set serve_dir=0 and go to SERVE_WAIT.
REQ-029 A start event in SERVE_WAIT, PLAY or POINT SHALL be ignored.
REQ-030 Total latency from a point pulse at cycle n SHALL be: score updated at n+1, POINT at n+1, SERVE_WAIT or GAME_OVER at n+2, PLAY at n+2+SERVE_DELAY.
REQ-031 The serve counter SHALL be 26 bits, counting down from SERVE_DELAY-1 to 0.
REQ-032 All outputs SHALL be registered, or decoded from registered state only.

Reset
REQ-033 When rst=1 at a clock edge, the block SHALL enter IDLE from any state (including mid-serve and GAME_OVER), with p1_score=0, p2_score=0, serve_dir=0, winner=00, game_over=0, ball_reset=1, play_en=0 and counter=0.
REQ-034 The start edge detector SHALL reset its history to 1, so a button held through reset does not produce a start event.

Verification
REQ-035 Reset then start pulse, with SERVE_DELAY=4: IDLE then SERVE_WAIT for exactly 4 cycles, then PLAY with play_en=1 and ball_reset=0.
REQ-036 In PLAY, a p2_point pulse at cycle n: p2_score=1 and serve_dir=0 at n+1, state=POINT at n+1, SERVE_WAIT at n+2.
REQ-037 With WIN_SCORE=3 and three p1_point rallies: after the third, game_over=1, winner=01, p1_score=3; further point pulses change nothing; a start event clears the scores and re-serves.
REQ-038 Simultaneous p1_point and p2_point in PLAY: scores unchanged, state goes to SERVE_WAIT, serve_dir unchanged.
REQ-039 Point pulses during SERVE_WAIT, and a start event during PLAY: no state change and no score change.
REQ-040 rst asserted mid-SERVE_WAIT with scores 2:1 and start held high: scores return to 0:0, state returns to IDLE, and no spurious start event occurs after rst is released.

Source files
------------

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - match sequencer for a two-player paddle game
// Tracks scores, times each serve and declares the match winner.
module game_sequencer #(
   parameter int WIN_SCORE   = 9,
   parameter int SERVE_DELAY = 50000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       p1_point,
   input  logic       p2_point,
   output logic [3:0] p1_score,
   output logic [3:0] p2_score,
   output logic       ball_reset,
   output logic       play_en,
   output logic       serve_dir,
   output logic       game_over,
   output logic [1:0] winner,
   output logic [2:0] state
);

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_SERVE_WAIT = 3'd1;
   localparam logic [2:0] S_PLAY       = 3'd2;
   localparam logic [2:0] S_POINT      = 3'd3;
   localparam logic [2:0] S_GAME_OVER  = 3'd4;

   localparam logic [3:0]  WIN_VAL   = 4'(WIN_SCORE);
   localparam logic [25:0] SERVE_LD  = 26'(SERVE_DELAY - 1);

   logic [2:0]  state_q, state_d;
   logic [3:0]  p1_q, p1_d;
   logic [3:0]  p2_q, p2_d;
   logic        dir_q, dir_d;
   logic [1:0]  winner_q, winner_d;
   logic [25:0] cnt_q, cnt_d;
   logic        start_prev_q, start_prev_d;
   logic        start_ev;

   always_comb begin
      state_d      = state_q;
      p1_d         = p1_q;
      p2_d         = p2_q;
      dir_d        = dir_q;
      winner_d     = winner_q;
      cnt_d        = cnt_q;
      start_prev_d = start;
      start_ev     = start & ~start_prev_q;

      case (state_q)
         S_IDLE: begin
            if (start_ev) begin
               state_d = S_SERVE_WAIT;
               cnt_d   = SERVE_LD;
            end
         end
         S_SERVE_WAIT: begin
            if (cnt_q == 26'd0) begin
               state_d = S_PLAY;
            end else begin
               cnt_d = cnt_q - 26'd1;
            end
         end
         S_PLAY: begin
            if (p1_point && !p2_point) begin
               if (p1_q != WIN_VAL) p1_d = p1_q + 4'd1;
               dir_d   = 1'b1;
               state_d = S_POINT;
            end else if (p2_point && !p1_point) begin
               if (p2_q != WIN_VAL) p2_d = p2_q + 4'd1;
               dir_d   = 1'b0;
               state_d = S_POINT;
            end else if (p1_point && p2_point) begin
               // tied rally: replay the serve without touching score or direction
               state_d = S_SERVE_WAIT;
               cnt_d   = SERVE_LD;
            end
         end
         S_POINT: begin
            if (p1_q == WIN_VAL) begin
               state_d  = S_GAME_OVER;
               winner_d = 2'b01;
            end else if (p2_q == WIN_VAL) begin
               state_d  = S_GAME_OVER;
               winner_d = 2'b10;
            end else begin
               state_d = S_SERVE_WAIT;
               cnt_d   = SERVE_LD;
            end
         end
         S_GAME_OVER: begin
            if (start_ev) begin
               p1_d     = 4'd0;
               p2_d     = 4'd0;
               winner_d = 2'b00;
               dir_d    = 1'b0;
               state_d  = S_SERVE_WAIT;
               cnt_d    = SERVE_LD;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         p1_q         <= 4'd0;
         p2_q         <= 4'd0;
         dir_q        <= 1'b0;
         winner_q     <= 2'b00;
         cnt_q        <= 26'd0;
         start_prev_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         p1_q         <= p1_d;
         p2_q         <= p2_d;
         dir_q        <= dir_d;
         winner_q     <= winner_d;
         cnt_q        <= cnt_d;
         start_prev_q <= start_prev_d;
      end
   end

   assign p1_score   = p1_q;
   assign p2_score   = p2_q;
   assign serve_dir  = dir_q;
   assign winner     = winner_q;
   assign state      = state_q;
   assign play_en    = (state_q == S_PLAY);
   assign ball_reset = (state_q != S_PLAY);
   assign game_over  = (state_q == S_GAME_OVER);

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - scoreboard bench for game_sequencer
// Random rally stimulus against a cycle-level match model.
module tb_game_sequencer;

   localparam int W = 3;
   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst, start, p1_point, p2_point;
   logic [3:0] p1_score, p2_score;
   logic       ball_reset, play_en, serve_dir, game_over;
   logic [1:0] winner;
   logic [2:0] state;

   game_sequencer #(.WIN_SCORE(W), .SERVE_DELAY(D)) dut (
      .clk(clk), .rst(rst), .start(start), .p1_point(p1_point), .p2_point(p2_point),
      .p1_score(p1_score), .p2_score(p2_score), .ball_reset(ball_reset), .play_en(play_en),
      .serve_dir(serve_dir), .game_over(game_over), .winner(winner), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] st;
      logic [3:0] s1;
      logic [3:0] s2;
      logic       dir;
      logic [1:0] win;
      logic       go;
      logic       br;
      logic       pe;
   } snap_t;

   snap_t exp_q[$];
   int    n_checks = 0;
   int    n_pass   = 0;

   // Match model: phase names follow the published state numbers
   localparam int IDLE = 0, SERVE = 1, PLAY = 2, POINT = 3, OVER = 4;
   int m_phase, m_s1, m_s2, m_dir, m_win, m_left, m_prev;

   task automatic model_step(input logic r, input logic s, input logic a, input logic b);
      snap_t e;
      bit    ev;
      if (r) begin
         m_phase = IDLE; m_s1 = 0; m_s2 = 0; m_dir = 0; m_win = 0; m_left = 0; m_prev = 1;
      end else begin
         ev     = s && (m_prev == 0);
         m_prev = s ? 1 : 0;
         case (m_phase)
            IDLE:  if (ev) begin m_phase = SERVE; m_left = D; end
            SERVE: begin
               m_left = m_left - 1;
               if (m_left == 0) m_phase = PLAY;
            end
            PLAY: begin
               if (a && !b) begin m_s1 = (m_s1 < W) ? m_s1 + 1 : W; m_dir = 1; m_phase = POINT; end
               else if (b && !a) begin m_s2 = (m_s2 < W) ? m_s2 + 1 : W; m_dir = 0; m_phase = POINT; end
               else if (a && b) begin m_phase = SERVE; m_left = D; end
            end
            POINT: begin
               if (m_s1 == W) begin m_phase = OVER; m_win = 1; end
               else if (m_s2 == W) begin m_phase = OVER; m_win = 2; end
               else begin m_phase = SERVE; m_left = D; end
            end
            default: if (ev) begin
               m_s1 = 0; m_s2 = 0; m_win = 0; m_dir = 0; m_phase = SERVE; m_left = D;
            end
         endcase
      end
      e.st  = 3'(m_phase);
      e.s1  = 4'(m_s1);
      e.s2  = 4'(m_s2);
      e.dir = (m_dir != 0);
      e.win = 2'(m_win);
      e.go  = (m_phase == OVER);
      e.br  = (m_phase != PLAY);
      e.pe  = (m_phase == PLAY);
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic r, input logic s, input logic a, input logic b);
      rst = r; start = s; p1_point = a; p2_point = b;
      model_step(r, s, a, b);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      snap_t act, e;
      if (exp_q.size() != 0) begin
         e   = exp_q.pop_front();
         act = '{state, p1_score, p2_score, serve_dir, winner, game_over, ball_reset, play_en};
         n_checks++;
         if (act === e) n_pass++;
         else $display("FAIL outputs t=%0t: actual st=%0d sc=%0d:%0d dir=%0d win=%0d go=%0d br=%0d pe=%0d, required st=%0d sc=%0d:%0d dir=%0d win=%0d go=%0d br=%0d pe=%0d",
            $time, act.st, act.s1, act.s2, act.dir, act.win, act.go, act.br, act.pe,
            e.st, e.s1, e.s2, e.dir, e.win, e.go, e.br, e.pe);
      end
   end

   initial begin
      logic s;
      s = 1'b1;
      // reset with start held high: no start event may follow release
      drive(1, 1, 0, 0);
      drive(1, 1, 0, 0);
      for (int i = 0; i < 4; i++) drive(0, 1, 0, 0);
      drive(0, 0, 0, 0);
      drive(0, 1, 0, 0);
      for (int i = 0; i < D + 1; i++) drive(0, 1, 0, 0);
      drive(0, 1, 0, 1);
      drive(0, 1, 1, 1);
      for (int i = 0; i < D + 2; i++) drive(0, 1, 1, 1);
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(7) == 0) s = ~s;
         drive(($urandom_range(299) == 0), s,
               ($urandom_range(5) == 0), ($urandom_range(5) == 0));
      end
      drive(0, s, 0, 0);
      @(negedge clk);
      #1;
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain: actual %0d pending, required 0", exp_q.size());
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
